tlk2711_axi_mem_slave: RTL and testbench

AXI4 slave responder with on-chip memory. It is the target end of the TLK2711 DMA master ports (read channel for TX, write channel for RX). It serves bursts from an internal word array, so the link path can be exercised on the board or in simulation without the PS DDR. The read and write channels are independent. Each channel accepts one outstanding burst at a time.

---
 rtl/tlk2711_axi_mem_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_tlk2711_axi_mem_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 slave backed by an on-chip word array: target for the TLK2711 DMA masters.
// Independent read and write FSMs, one outstanding burst each, all outputs registered.
module tlk2711_axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [15:0]             o_rd_burst_cnt,
  output logic [15:0]             o_wr_burst_cnt
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam logic [2:0] SIZE_OK = 3'(LSB);

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  function automatic logic [MEM_AW-1:0] next_idx(input logic [MEM_AW-1:0] idx, input logic [1:0] burst);
    if (burst == 2'b00) next_idx = idx;
    else                next_idx = idx + {{(MEM_AW-1){1'b0}}, 1'b1};
  endfunction

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  rstate_t               rstate_q, rstate_d;
  logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
  logic [8:0]            r_beat_q, r_beat_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;

  wstate_t               wstate_q, wstate_d;
  logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
  logic [8:0]            w_beat_q, w_beat_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d, w_serr_q, w_serr_d, w_err_s, mem_we_s;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;

  logic [MEM_AW-1:0]     ar_idx_s, r_nidx_s;
  logic                  unused_s;

  assign ar_idx_s = s_axi_araddr[LSB +: MEM_AW];
  assign r_nidx_s = next_idx(r_idx_q, r_burst_q);
  assign unused_s = ^{1'b0, s_axi_araddr, s_axi_awaddr};

  always_comb begin
    rstate_d  = rstate_q;  r_idx_d  = r_idx_q;  r_beat_d = r_beat_q;
    r_len_d   = r_len_q;   r_burst_d = r_burst_q;
    arready_d = arready_q; rvalid_d = rvalid_q; rlast_d  = rlast_q;
    rdata_d   = rdata_q;   rresp_d  = rresp_q;  rid_d    = rid_q;
    rd_cnt_d  = rd_cnt_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          r_idx_d   = ar_idx_s;
          r_beat_d  = 9'd0;
          r_len_d   = s_axi_arlen;
          r_burst_d = s_axi_arburst;
          rid_d     = s_axi_arid;
          rvalid_d  = 1'b1;
          rdata_d   = mem[ar_idx_s];
          rlast_d   = (s_axi_arlen == 8'd0);
          rresp_d   = (s_axi_arsize != SIZE_OK) ? 2'b10 : 2'b00;
        end else begin
          rvalid_d  = 1'b0;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b0;
            rd_cnt_d  = rd_cnt_q + 16'd1;
          end else begin
            r_idx_d   = r_nidx_s;
            r_beat_d  = r_beat_q + 9'd1;
            rdata_d   = mem[r_nidx_s];
            rlast_d   = ((r_beat_q + 9'd1) == {1'b0, r_len_q});
          end
        end else begin
          rvalid_d = rvalid_q;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d  = wstate_q;  w_idx_d  = w_idx_q;  w_beat_d = w_beat_q;
    w_len_d   = w_len_q;   w_burst_d = w_burst_q;
    w_err_d   = w_err_q;   w_serr_d = w_serr_q;
    awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    bresp_d   = bresp_q;   bid_d    = bid_q;    wr_cnt_d = wr_cnt_q;
    w_err_s   = w_err_q;   mem_we_s = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_idx_d   = s_axi_awaddr[LSB +: MEM_AW];
          w_beat_d  = 9'd0;
          w_len_d   = s_axi_awlen;
          w_burst_d = s_axi_awburst;
          bid_d     = s_axi_awid;
          w_err_d   = 1'b0;
          w_serr_d  = (s_axi_awsize != SIZE_OK);
        end else begin
          wready_d  = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          // Overrun beats are dropped; an early wlast truncates the burst.
          mem_we_s = (w_beat_q <= {1'b0, w_len_q});
          w_err_s  = w_err_q | (w_beat_q > {1'b0, w_len_q})
                   | (s_axi_wlast & (w_beat_q < {1'b0, w_len_q}));
          w_err_d  = w_err_s;
          w_idx_d  = next_idx(w_idx_q, w_burst_q);
          w_beat_d = (w_beat_q == 9'd256) ? w_beat_q : (w_beat_q + 9'd1);
          if (s_axi_wlast) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (w_err_s | w_serr_q) ? 2'b10 : 2'b00;
          end else begin
            wready_d = 1'b1;
          end
        end else begin
          wready_d = wready_q;
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b0;
          wr_cnt_d  = wr_cnt_q + 16'd1;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;  r_idx_q  <= '0;   r_beat_q <= 9'd0;
      r_len_q   <= 8'd0;    r_burst_q <= 2'b00;
      arready_q <= 1'b0;    rvalid_q <= 1'b0; rlast_q  <= 1'b0;
      rdata_q   <= '0;      rresp_q  <= 2'b00; rid_q   <= '0;
      rd_cnt_q  <= 16'd0;
      wstate_q  <= W_IDLE;  w_idx_q  <= '0;   w_beat_q <= 9'd0;
      w_len_q   <= 8'd0;    w_burst_q <= 2'b00;
      w_err_q   <= 1'b0;    w_serr_q <= 1'b0;
      awready_q <= 1'b0;    wready_q <= 1'b0; bvalid_q <= 1'b0;
      bresp_q   <= 2'b00;   bid_q    <= '0;   wr_cnt_q <= 16'd0;
    end else begin
      rstate_q  <= rstate_d;  r_idx_q  <= r_idx_d;  r_beat_q <= r_beat_d;
      r_len_q   <= r_len_d;   r_burst_q <= r_burst_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q  <= rlast_d;
      rdata_q   <= rdata_d;   rresp_q  <= rresp_d;  rid_q    <= rid_d;
      rd_cnt_q  <= rd_cnt_d;
      wstate_q  <= wstate_d;  w_idx_q  <= w_idx_d;  w_beat_q <= w_beat_d;
      w_len_q   <= w_len_d;   w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;   w_serr_q <= w_serr_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bresp_q   <= bresp_d;   bid_q    <= bid_d;    wr_cnt_q <= wr_cnt_d;
    end
  end

  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rlast    = rlast_q;
  assign s_axi_rresp    = rresp_q;
  assign s_axi_rid      = rid_q;
  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = wready_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = bresp_q;
  assign s_axi_bid      = bid_q;
  assign o_rd_burst_cnt = rd_cnt_q;
  assign o_wr_burst_cnt = wr_cnt_q;

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Directed bench for tlk2711_axi_mem_slave: write/read bursts, backpressure,
// strobes, FIXED bursts, error responses, index wrap and mid-burst reset.
module tb_tlk2711_axi_mem_slave;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_axi_arid, s_axi_rid, s_axi_awid, s_axi_bid;
  logic [31:0]  s_axi_araddr, s_axi_awaddr;
  logic [7:0]   s_axi_arlen, s_axi_awlen;
  logic [2:0]   s_axi_arsize, s_axi_awsize;
  logic [1:0]   s_axi_arburst, s_axi_awburst, s_axi_rresp, s_axi_bresp;
  logic         s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic         s_axi_bvalid, s_axi_bready;
  logic [127:0] s_axi_rdata, s_axi_wdata;
  logic [15:0]  s_axi_wstrb, o_rd_burst_cnt, o_wr_burst_cnt;

  logic [127:0] wd [16];
  logic [15:0]  ws [16];
  logic [127:0] ed [16];
  logic [1:0]   resp;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tlk2711_axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .o_rd_burst_cnt(o_rd_burst_cnt), .o_wr_burst_cnt(o_wr_burst_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input int nb, output logic [1:0] bresp);
    int t;
    s_axi_awid = 4'h3; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_wait", 128'(t < 50), 128'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == nb - 1); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 50) begin @(posedge clk); #1; t++; end
      chk("w_wait", 128'(t < 50), 128'd1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(posedge clk); #1; t++; end
    chk("b_wait", 128'(t < 50), 128'd1);
    chk("bid", 128'(s_axi_bid), 128'h3);
    bresp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id, input int nb,
                         input logic toggle, input logic [1:0] exp_resp);
    int t, b, cyc;
    logic stall;
    logic [127:0] held;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_wait", 128'(t < 50), 128'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    chk("r_first", 128'(s_axi_rvalid), 128'd1);
    b = 0; cyc = 0;
    while (b < nb && cyc < 200) begin
      s_axi_rready = toggle ? (cyc % 2 == 0) : 1'b1;
      stall = s_axi_rvalid && !s_axi_rready;
      held  = s_axi_rdata;
      if (s_axi_rvalid && s_axi_rready) begin
        chk("rdata", s_axi_rdata, ed[b]);
        chk("rlast", 128'(s_axi_rlast), 128'(b == nb - 1));
        chk("rresp", 128'(s_axi_rresp), 128'(exp_resp));
        chk("rid", 128'(s_axi_rid), 128'(id));
        if (!toggle) chk("r_consec", 128'(cyc), 128'(b));
        b++;
      end
      @(posedge clk); #1;
      cyc++;
      if (stall) chk("r_stable", s_axi_rdata, held);
    end
    s_axi_rready = 1'b0;
    chk("r_beats", 128'(b), 128'(nb));
    chk("r_idle", 128'(s_axi_rvalid), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    s_axi_arid = 4'h0; s_axi_araddr = 32'h0; s_axi_arlen = 8'h0; s_axi_arsize = 3'd4;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awid = 4'h0; s_axi_awaddr = 32'h0; s_axi_awlen = 8'h0; s_axi_awsize = 3'd4;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wdata = 128'h0; s_axi_wstrb = 16'h0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 128'(s_axi_arready), 128'd0);
    chk("rst_awready", 128'(s_axi_awready), 128'd0);
    chk("rst_wready", 128'(s_axi_wready), 128'd0);
    chk("rst_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("rst_bvalid", 128'(s_axi_bvalid), 128'd0);
    chk("rst_rdata", s_axi_rdata, 128'd0);
    chk("rst_cnts", 128'({o_rd_burst_cnt, o_wr_burst_cnt}), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_arready", 128'(s_axi_arready), 128'd1);
    chk("post_rst_awready", 128'(s_axi_awready), 128'd1);

    // Write 1..4 at 0x100, read back with and without backpressure
    for (int i = 0; i < 4; i++) begin wd[i] = 128'(i + 1); ws[i] = 16'hFFFF; ed[i] = 128'(i + 1); end
    do_write(32'h100, 8'd3, 2'b01, 3'd4, 4, resp);
    chk("wr_bresp", 128'(resp), 128'd0);
    chk("wr_cnt1", 128'(o_wr_burst_cnt), 128'd1);
    do_read(32'h100, 8'd3, 2'b01, 3'd4, 4'h5, 4, 1'b0, 2'b00);
    chk("rd_cnt1", 128'(o_rd_burst_cnt), 128'd1);
    do_read(32'h100, 8'd3, 2'b01, 3'd4, 4'h9, 4, 1'b1, 2'b00);
    chk("rd_cnt2", 128'(o_rd_burst_cnt), 128'd2);
    // Upper address bits ignored: 0x4100 aliases 0x100
    do_read(32'h4100, 8'd0, 2'b01, 3'd4, 4'h2, 1, 1'b0, 2'b00);

    // FIXED burst with partial strobe
    wd[0] = {16{8'hAA}}; ws[0] = 16'hFFFF;
    wd[1] = {16{8'h55}}; ws[1] = 16'h000F;
    do_write(32'h200, 8'd1, 2'b00, 3'd4, 2, resp);
    chk("fixed_bresp", 128'(resp), 128'd0);
    ed[0] = {{12{8'hAA}}, {4{8'h55}}};
    do_read(32'h200, 8'd0, 2'b01, 3'd4, 4'h1, 1, 1'b0, 2'b00);

    // Early wlast: only two of four words overwritten
    for (int i = 0; i < 4; i++) begin wd[i] = 128'(8'hC0 + i); ws[i] = 16'hFFFF; end
    do_write(32'h300, 8'd3, 2'b01, 3'd4, 4, resp);
    chk("pre_bresp", 128'(resp), 128'd0);
    wd[0] = 128'h11; wd[1] = 128'h22;
    do_write(32'h300, 8'd3, 2'b01, 3'd4, 2, resp);
    chk("early_wlast_bresp", 128'(resp), 128'd2);
    chk("wr_cnt4", 128'(o_wr_burst_cnt), 128'd4);
    ed[0] = 128'h11; ed[1] = 128'h22; ed[2] = 128'hC2; ed[3] = 128'hC3;
    do_read(32'h300, 8'd3, 2'b01, 3'd4, 4'h4, 4, 1'b0, 2'b00);

    // Bad arsize: data returned with SLVERR on every beat
    ed[0] = 128'd1; ed[1] = 128'd2;
    do_read(32'h100, 8'd1, 2'b01, 3'd3, 4'h7, 2, 1'b0, 2'b10);

    // Index wrap 1023 -> 0
    wd[0] = 128'hE0; wd[1] = 128'hE1; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
    do_write(32'h3FF0, 8'd1, 2'b01, 3'd4, 2, resp);
    chk("wrap_bresp", 128'(resp), 128'd0);
    ed[0] = 128'hE0; ed[1] = 128'hE1;
    do_read(32'h3FF0, 8'd1, 2'b01, 3'd4, 4'h6, 2, 1'b0, 2'b00);
    ed[0] = 128'hE1;
    do_read(32'h0, 8'd0, 2'b01, 3'd4, 4'h6, 1, 1'b0, 2'b00);

    // Reset during beat 5 of a 16-beat read
    for (int i = 0; i < 16; i++) begin wd[i] = 128'(16'h100 + i); ws[i] = 16'hFFFF; end
    do_write(32'h100, 8'd15, 2'b01, 3'd4, 16, resp);
    chk("w16_bresp", 128'(resp), 128'd0);
    s_axi_arid = 4'hA; s_axi_araddr = 32'h100; s_axi_arlen = 8'd15;
    s_axi_arburst = 2'b01; s_axi_arsize = 3'd4; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar16_wait", 128'(t < 50), 128'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("beat5_data", s_axi_rdata, 128'h104);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", 128'(s_axi_rvalid), 128'd0);
    chk("midrst_rdata", s_axi_rdata, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_axi_rready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arready", 128'(s_axi_arready), 128'd1);
    chk("midrst_rdcnt", 128'(o_rd_burst_cnt), 128'd0);
    for (int i = 0; i < 4; i++) ed[i] = 128'(16'h100 + i);
    do_read(32'h100, 8'd3, 2'b01, 3'd4, 4'hB, 4, 1'b0, 2'b00);
    chk("final_rdcnt", 128'(o_rd_burst_cnt), 128'd1);
    chk("final_wrcnt", 128'(o_wr_burst_cnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
